// File: rtl/level_sequencer.sv
// level_sequencer: block-stacker level/tick controller; optional 16-bit score counter via LEVEL_SEQ_SCORE_EN.
module level_sequencer #(
  parameter int NUM_LEVELS = 15,
  parameter int LEVEL_W = 4,
  parameter int CNT_W = 24,
  parameter logic [CNT_W-1:0] SPEED_BASE = 24'd5_000_000,
  parameter logic [CNT_W-1:0] SPEED_STEP = 24'd300_000,
  parameter logic [CNT_W-1:0] SPEED_MIN = 24'd500_000,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               land_valid,
  input  logic               land_hit,
  output logic [LEVEL_W-1:0] level,
  output logic [CNT_W-1:0]   speed_period,
  output logic               move_tick,
  output logic               level_up,
  output logic               win,
  output logic               lose
`ifdef LEVEL_SEQ_SCORE_EN
  , output logic [15:0]      score
`endif
);
  localparam logic [1:0] PLAY = 2'd0, ADV = 2'd1, WIN = 2'd2, LOSE = 2'd3;
  localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_TOP = LEVEL_W'(NUM_LEVELS);
  localparam int PW = CNT_W + LEVEL_W;
  // Wide arithmetic so a large level never wraps the product before saturating to the floor
  function automatic logic [CNT_W-1:0] period_f(input logic [LEVEL_W-1:0] l);
    logic [PW-1:0] p, b;
    p = PW'(l - 1'b1) * PW'(SPEED_STEP);
    b = PW'(SPEED_BASE);
    period_f = (p >= b || b - p < PW'(SPEED_MIN)) ? SPEED_MIN : CNT_W'(b - p);
  endfunction
  logic [1:0] state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic tick_q, up_q, win_q, lose_q;
  logic landing, holding, hold_end;
  assign speed_period = period_f(level_q);
  always_comb begin
    landing = state_q == PLAY && land_valid;
    holding = state_q == WIN || state_q == LOSE;
    hold_end = holding && hold_q == HOLD_LAST;
    state_d = landing ? (land_hit ? (level_q == LEVEL_TOP ? WIN : ADV) : LOSE)
            : state_q == ADV ? PLAY
            : hold_end ? PLAY : state_q;
    level_d = state_d == ADV ? level_q + 1'b1 : hold_end ? LEVEL_W'(1) : level_q;
    div_d = (state_q == PLAY && state_d == PLAY && div_q != speed_period - 1'b1) ? div_q + 1'b1 : '0;
    hold_d = (holding && !hold_end) ? hold_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PLAY;
      level_q <= LEVEL_W'(1);
      div_q <= '0;
      hold_q <= '0;
      tick_q <= 1'b0;
      up_q <= 1'b0;
      win_q <= 1'b0;
      lose_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      div_q <= div_d;
      hold_q <= hold_d;
      tick_q <= state_d == PLAY && div_d == period_f(level_d) - 1'b1;
      up_q <= state_d == ADV;
      win_q <= state_d == WIN;
      lose_q <= state_d == LOSE;
    end
  end
  assign level = level_q;
  assign move_tick = tick_q;
  assign level_up = up_q;
  assign win = win_q;
  assign lose = lose_q;
`ifdef LEVEL_SEQ_SCORE_EN
  logic [15:0] score_q, score_d;
  always_comb
    score_d = (hold_end && state_q == LOSE) ? 16'd0
            : (landing && land_hit && score_q != 16'hFFFF) ? score_q + 16'd1 : score_q;
  always_ff @(posedge clk)
    score_q <= reset ? 16'd0 : score_d;
  assign score = score_q;
`endif
endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: event-timed reference model plus directed landings for level_sequencer.
module tb_level_sequencer;
  localparam int NL = 4, SB = 10, SS = 3, SM = 2, HOLD = 5;
  logic clk = 0, reset = 1, land_valid = 0, land_hit = 0;
  logic [3:0] level;
  logic [23:0] speed_period;
  logic move_tick, level_up, win, lose;
`ifdef LEVEL_SEQ_SCORE_EN
  logic [15:0] score;
`endif
  level_sequencer #(
    .NUM_LEVELS(NL), .LEVEL_W(4), .CNT_W(24),
    .SPEED_BASE(24'd10), .SPEED_STEP(24'd3), .SPEED_MIN(24'd2), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .land_valid(land_valid), .land_hit(land_hit),
    .level(level), .speed_period(speed_period), .move_tick(move_tick),
    .level_up(level_up), .win(win), .lose(lose)
`ifdef LEVEL_SEQ_SCORE_EN
    , .score(score)
`endif
  );
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: kind 0=play 1=advance 2=win 3=lose; play timing derived from the cycle play began
  int cyc = 0, m_kind = 0, m_level = 1, m_play0 = 0, m_until = 0, m_score = 0, rst_cyc = 0;
  bit armed = 0;
  always @(posedge clk) begin
    int c;
    c = cyc;
    cyc = cyc + 1;
    if (reset) begin
      armed = 1; m_kind = 0; m_level = 1; m_play0 = cyc; m_score = 0; rst_cyc = cyc;
    end else if (m_kind == 0) begin
      if (land_valid && land_hit) begin
        m_score = m_score < 65535 ? m_score + 1 : m_score;
        if (m_level < NL) begin m_kind = 1; m_level++; m_play0 = cyc + 1; end
        else begin m_kind = 2; m_until = cyc + HOLD - 1; end
      end else if (land_valid) begin
        m_kind = 3; m_until = cyc + HOLD - 1;
      end
    end else if (m_kind == 1) m_kind = 0;
    else if (c == m_until) begin
      if (m_kind == 3) m_score = 0;
      m_kind = 0; m_level = 1; m_play0 = cyc;
    end
  end
  int tick_cnt = 0, win_cnt = 0, lose_cnt = 0, first_tick = 0;
  always @(negedge clk) if (armed) begin
    int per;
    bit exp_tick;
    per = SB - (m_level - 1) * SS;
    if (per < SM) per = SM;
    exp_tick = m_kind == 0 && ((cyc - m_play0 + 1) % per == 0);
    check("level", level, m_level);
    check("speed_period", speed_period, per);
    check("move_tick", move_tick, exp_tick);
    check("level_up", level_up, m_kind == 1);
    check("win", win, m_kind == 2);
    check("lose", lose, m_kind == 3);
`ifdef LEVEL_SEQ_SCORE_EN
    check("score", score, m_score);
`endif
    if (move_tick && first_tick == 0) first_tick = cyc - rst_cyc + 1;
    tick_cnt += move_tick;
    win_cnt += win;
    lose_cnt += lose;
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic land(input bit hit);
    @(negedge clk);
    land_valid = 1; land_hit = hit;
    @(negedge clk);
    land_valid = 0; land_hit = 0;
  endtask
  initial begin
    int w;
    idle(3);
    reset = 0;
    idle(30);
    check("idle_ticks", tick_cnt, 3);
    check("first_tick_cycle", first_tick, 10);
    check("idle_level", level, 1);
    check("idle_period", speed_period, 10);
    land(1);
    check("adv1_up", level_up, 1);
    check("adv1_period", speed_period, 7);
    idle(19);
    land(1);
    check("adv2_level", level, 3);
    check("adv2_period", speed_period, 4);
    idle(19);
    land(1);
    check("adv3_level", level, 4);
    check("adv3_period_floor", speed_period, 2);
    idle(19);
    win_cnt = 0;
    land(1);
    check("win_on", win, 1);
    land(0);
    idle(8);
    check("win_len", win_cnt, HOLD);
    check("win_ignores_land", lose_cnt, 0);
    check("win_exit_level", level, 1);
`ifdef LEVEL_SEQ_SCORE_EN
    check("win_score_kept", score, 4);
`endif
    land(1);
    idle(5);
    land(1);
    check("pre_miss_level", level, 3);
    idle(5);
    lose_cnt = 0;
    land(0);
    check("lose_on", lose, 1);
    idle(8);
    check("lose_len", lose_cnt, HOLD);
    check("lose_exit_level", level, 1);
    check("lose_exit_period", speed_period, 10);
`ifdef LEVEL_SEQ_SCORE_EN
    check("lose_score_clear", score, 0);
`endif
    w = 0;
    @(negedge clk);
    while (!move_tick && w < 30) begin @(negedge clk); w++; end
    check("tick_found", w < 30, 1);
    land_valid = 1; land_hit = 1;
    @(negedge clk);
    land_valid = 0; land_hit = 0;
    check("coincident_up", level_up, 1);
    check("coincident_level", level, 2);
    idle(5);
    land(0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("reset_lose", lose, 0);
    check("reset_level", level, 1);
    idle(15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
